serial_uart_bridge: RTL and testbench

//  Downstream consumer of the processor's serial IO ports. Buffers bytes the CPU writes,

---
 rtl/serial_uart_bridge_if.sv | 20 ++
 rtl/serial_uart_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_serial_uart_bridge.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_uart_bridge_if.sv
// CPU-side serial port bundle of serial_uart_bridge: TX byte push and RX byte pop.
// A push completes on a cycle with serial_wren_out && serial_ready_in; a pop on serial_rden_out && serial_valid_in.
interface serial_uart_bridge_if;
    logic [7:0] serial_out;
    logic       serial_wren_out;
    logic       serial_rden_out;
    logic [7:0] serial_in;
    logic       serial_valid_in;
    logic       serial_ready_in;

    modport master (
        output serial_out, serial_wren_out, serial_rden_out,
        input  serial_in, serial_valid_in, serial_ready_in
    );

    modport slave (
        input  serial_out, serial_wren_out, serial_rden_out,
        output serial_in, serial_valid_in, serial_ready_in
    );
endinterface

// File: rtl/serial_uart_bridge.sv
// CPU serial port to 8N1 UART bridge with TX/RX byte FIFOs and sticky RX error flags.
// Define SERIAL_UART_LOOPBACK_EN to feed the receiver from the internal transmit line.
module serial_uart_bridge #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_uart_bridge_if.slave  bus,
    output logic                 uart_txd,
    input  logic                 uart_rxd,
    input  logic                 err_clear,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic [1:0]           dbg_tx_state_o,
    output logic [2:0]           dbg_rx_state_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam int TXD = 1 << TX_DEPTH_LOG2;
    localparam int RXD = 1 << RX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL = (TX_DEPTH_LOG2 + 1)'(TXD);
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL = (RX_DEPTH_LOG2 + 1)'(RXD);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    // TX FIFO
    logic [7:0]               tx_mem_q [TXD];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
    logic [TX_DEPTH_LOG2:0]   tx_cnt_q;
    logic                     tx_push, tx_pop, tx_nonempty;
    logic [7:0]               tx_head;

    assign bus.serial_ready_in = (tx_cnt_q != TX_FULL);
    assign tx_push     = bus.serial_wren_out && bus.serial_ready_in;
    assign tx_nonempty = (tx_cnt_q != '0);
    assign tx_head     = tx_mem_q[tx_rd_q];

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= bus.serial_out;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
        end
    end

    // TX FSM: the next byte is popped either from IDLE or on the last STOP cycle, so frames abut.
    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_clk_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shift_q;
    logic             txd_q;
    logic             tx_bit_end;

    assign tx_bit_end = (tx_clk_q == BIT_LAST);
    assign tx_pop = tx_nonempty &&
                    ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_bit_end));

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_clk_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_clk_q <= tx_bit_end ? '0 : tx_clk_q + 1'b1;
            case (tx_state_q)
                TX_IDLE: begin
                    tx_clk_q <= '0;
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= tx_head;
                        txd_q      <= 1'b0;
                    end
                end
                TX_START: if (tx_bit_end) begin
                    tx_state_q <= TX_DATA;
                    tx_bit_q   <= '0;
                    txd_q      <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                end
                TX_DATA: if (tx_bit_end) begin
                    tx_bit_q <= tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= TX_STOP;
                        txd_q      <= 1'b1;
                    end else begin
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end
                TX_STOP: if (tx_bit_end) begin
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= tx_head;
                        txd_q      <= 1'b0;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    logic rx_line;
`ifdef SERIAL_UART_LOOPBACK_EN
    assign uart_txd = 1'b1;
    assign rx_line  = txd_q;
`else
    assign uart_txd = txd_q;
    assign rx_line  = uart_rxd;
`endif

    // RX synchronizer and FSM; START re-checks the line half a bit in to reject glitches.
    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] rx_clk_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_stop_end, rx_push, rx_frame_set;

    assign rx_stop_end  = (rx_state_q == RX_STOP) && (rx_clk_q == BIT_LAST);
    assign rx_push      = rx_stop_end && rx_sync_q;
    assign rx_frame_set = rx_stop_end && !rx_sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_clk_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q <= rx_line;
            rx_sync_q <= rx_meta_q;
            rx_clk_q  <= rx_clk_q + 1'b1;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_clk_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: if (rx_clk_q == BIT_HALF) begin
                    rx_clk_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_clk_q == BIT_LAST) begin
                    rx_clk_q   <= '0;
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end
                RX_STOP: if (rx_stop_end) begin
                    rx_clk_q   <= '0;
                    rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end
                RX_WAIT_HIGH: begin
                    rx_clk_q <= '0;
                    if (rx_sync_q) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // RX FIFO: a same-cycle pop frees the slot for an incoming byte when full.
    logic [7:0]               rx_mem_q [RXD];
    logic [RX_DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
    logic [RX_DEPTH_LOG2:0]   rx_cnt_q;
    logic                     rx_pop, rx_accept, rx_nonempty;

    assign rx_nonempty         = (rx_cnt_q != '0);
    assign rx_pop              = bus.serial_rden_out && rx_nonempty;
    assign rx_accept           = rx_push && ((rx_cnt_q != RX_FULL) || rx_pop);
    assign bus.serial_valid_in = rx_nonempty;
    assign bus.serial_in       = rx_nonempty ? rx_mem_q[rx_rd_q] : 8'h00;

    always_ff @(posedge clock) begin
        if (rx_accept) rx_mem_q[rx_wr_q] <= rx_shift_q;
    end

    logic rx_overrun_q, rx_frame_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr_q        <= '0;
            rx_rd_q        <= '0;
            rx_cnt_q       <= '0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            if (rx_accept) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)    rx_rd_q <= rx_rd_q + 1'b1;
            if (rx_accept && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
            else if (!rx_accept && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
            if (rx_push && !rx_accept) rx_overrun_q <= 1'b1;
            else if (err_clear)        rx_overrun_q <= 1'b0;
            if (rx_frame_set)          rx_frame_err_q <= 1'b1;
            else if (err_clear)        rx_frame_err_q <= 1'b0;
        end
    end

    assign rx_overrun     = rx_overrun_q;
    assign rx_frame_err   = rx_frame_err_q;
    assign dbg_tx_state_o = tx_state_q;
    assign dbg_rx_state_o = rx_state_q;
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Scoreboard bench for serial_uart_bridge: a UART line decoder checks TX frames, a pop monitor checks RX bytes.
module tb_serial_uart_bridge;
    localparam int C     = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       err_clear = 1'b0;
    logic       uart_txd, rx_overrun, rx_frame_err;
    logic [1:0] dbg_tx_state;
    logic [2:0] dbg_rx_state;

    serial_uart_bridge_if bus();

    serial_uart_bridge #(.CLKS_PER_BIT(C), .TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
        .clock(clk), .reset(rst), .bus(bus),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd), .err_clear(err_clear),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
        .dbg_tx_state_o(dbg_tx_state), .dbg_rx_state_o(dbg_rx_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    logic tx_mon_en = 1'b1;
    logic tx_busy = 1'b0;
    logic tx_gap_chk = 1'b0;
    logic rx_auto_pop = 1'b1;
    int   tx_lat_exp = -1;
    int   tx_last_start = -1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // TX scoreboard: decode each frame from the line and compare bit-by-bit against the ideal 8N1 waveform.
    initial begin : tx_monitor
        logic [10*C-1:0] samp, exp_samp;
        logic [7:0] exp_b, got_b;
        int start;
        forever begin
            @(negedge clk);
            if (tx_mon_en && !rst && uart_txd === 1'b0) begin
                tx_busy = 1'b1;
                start = cyc;
                samp[0] = 1'b0;
                for (int i = 1; i < 10 * C; i++) begin
                    @(negedge clk);
                    samp[i] = uart_txd;
                end
                check("tx_expected_frame", tx_exp_q.size() != 0, 1);
                exp_b = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 8'h00;
                for (int i = 0; i < 10 * C; i++) begin
                    int b;
                    b = i / C;
                    exp_samp[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
                end
                for (int k = 0; k < 8; k++) got_b[k] = samp[(k + 1) * C + C / 2];
                check("tx_byte", got_b, exp_b);
                check("tx_wave", samp, exp_samp);
                if (tx_lat_exp >= 0) begin
                    check("tx_latency", start, tx_lat_exp);
                    tx_lat_exp = -1;
                end
                if (tx_gap_chk && tx_last_start >= 0) check("tx_gap", start - tx_last_start, 10 * C);
                tx_last_start = start;
                tx_busy = 1'b0;
            end
        end
    end

    // RX scoreboard: pop every presented byte and compare with the expected queue.
    initial begin : rx_monitor
        bus.serial_rden_out = 1'b0;
        forever begin
            @(negedge clk);
            bus.serial_rden_out = 1'b0;
            if (!rst && rx_auto_pop && bus.serial_valid_in === 1'b1) begin
                check("rx_expected_byte", rx_exp_q.size() != 0, 1);
                if (rx_exp_q.size() != 0) check("rx_byte", bus.serial_in, rx_exp_q.pop_front());
                bus.serial_rden_out = 1'b1;
            end
        end
    end

    task automatic tx_write(input logic [7:0] b);
        @(negedge clk);
        bus.serial_out = b;
        bus.serial_wren_out = 1'b1;
        tx_exp_q.push_back(b);
        @(negedge clk);
        bus.serial_wren_out = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd = f[i];
            repeat (C - 1) @(negedge clk);
        end
    endtask

    task automatic wait_tx_drain(input int budget);
        int n;
        n = 0;
        while ((tx_exp_q.size() != 0 || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain", tx_exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rx_drain(input int budget);
        int n;
        n = 0;
        while (rx_exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_drain", rx_exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #(600000);
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] b;
        int model_cnt;
        logic exp_overrun;
        bus.serial_out = 8'h00;
        bus.serial_wren_out = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_serial_in", bus.serial_in, 0);
        check("rst_valid", bus.serial_valid_in, 0);
        check("rst_ready", bus.serial_ready_in, 1);
        check("rst_overrun", rx_overrun, 0);
        check("rst_frame_err", rx_frame_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
`ifdef SERIAL_UART_LOOPBACK_EN
        tx_mon_en = 1'b0;
        rx_exp_q.push_back(8'h5A);
        tx_write(8'h5A);
        tx_exp_q.delete();
        wait_rx_drain(20 * C);
        check("loop_txd_idle", uart_txd, 1);
`else
        // single byte: waveform and start latency
        @(negedge clk);
        tx_lat_exp = cyc + 2;
        tx_exp_q.push_back(8'hA5);
        bus.serial_out = 8'hA5;
        bus.serial_wren_out = 1'b1;
        @(negedge clk);
        bus.serial_wren_out = 1'b0;
        wait_tx_drain(40 * C);

        // burst of 18: one byte leaves the FIFO right away, so 17 fit and the 18th is dropped
        tx_gap_chk = 1'b1;
        tx_last_start = -1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("tx_ready_burst", bus.serial_ready_in, (i < 17) ? 1 : 0);
            b = 8'($urandom);
            bus.serial_out = b;
            bus.serial_wren_out = 1'b1;
            if (i < 17) tx_exp_q.push_back(b);
        end
        @(negedge clk);
        bus.serial_wren_out = 1'b0;
        wait_tx_drain(20 * 10 * C);
        tx_gap_chk = 1'b0;

        // single RX byte held until popped
        rx_auto_pop = 1'b0;
        rx_exp_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        check("rx_valid_held", bus.serial_valid_in, 1);
        check("rx_head", bus.serial_in, 8'h3C);
        rx_auto_pop = 1'b1;
        repeat (3) @(negedge clk);
        check("rx_valid_after_pop", bus.serial_valid_in, 0);

        // short low glitch
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (12 * C) @(negedge clk);
        check("glitch_valid", bus.serial_valid_in, 0);
        check("glitch_frame_err", rx_frame_err, 0);
        check("glitch_overrun", rx_overrun, 0);

        // stop bit low
        send_rx(8'($urandom), 1'b0);
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("ferr_valid", bus.serial_valid_in, 0);
        check("ferr_set", rx_frame_err, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("ferr_clear", rx_frame_err, 0);

        // overrun: 17 frames into a 16-deep FIFO with no pops
        rx_auto_pop = 1'b0;
        model_cnt = 0;
        exp_overrun = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (model_cnt < DEPTH) begin
                rx_exp_q.push_back(b);
                model_cnt++;
            end else begin
                exp_overrun = 1'b1;
            end
            send_rx(b, 1'b1);
        end
        repeat (8) @(negedge clk);
        check("ovr_set", rx_overrun, exp_overrun);
        check("ovr_frame_err", rx_frame_err, 0);
        rx_auto_pop = 1'b1;
        wait_rx_drain(4 * DEPTH);
        check("ovr_sticky", rx_overrun, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("ovr_clear", rx_overrun, 0);

        // random traffic on both directions
        for (int i = 0; i < 6; i++) begin
            tx_write(8'($urandom));
            b = 8'($urandom);
            rx_exp_q.push_back(b);
            send_rx(b, 1'b1);
            repeat ($urandom_range(0, 3 * C)) @(negedge clk);
        end
        wait_rx_drain(20 * C);
        wait_tx_drain(20 * 10 * C);
        check("final_overrun", rx_overrun, 0);
        check("final_frame_err", rx_frame_err, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
